// File: rtl/dual_counter_sched_pkg.sv
// Shared encodings for the dual-counter scheduler: FSM states, datapath step
// select polarity and requester identifiers.
package dual_counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic STEP_FAST = 1'b0;
    localparam logic STEP_SLOW = 1'b1;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/dual_counter_scheduler_arb.sv
// Two-way round-robin arbiter: grants only while enabled, and remembers the
// last requester served so the other one wins the next tie.
module rr_arbiter_2
    import dual_counter_sched_pkg::*;
(
    input  logic       clk,
    input  logic       clear_n,
    input  logic [1:0] req_i,
    input  logic       enable_i,
    output logic [1:0] grant_o,
    output logic       last_served_o
);

    logic last_served_q;
    logic last_served_d;

    always_comb begin
        grant_o       = 2'b00;
        last_served_d = last_served_q;
        if (enable_i) begin
            case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = (last_served_q == REQ_A) ? 2'b10 : 2'b01;
                default: grant_o = 2'b00;
            endcase
        end
        if (grant_o[REQ_A]) begin
            last_served_d = REQ_A;
        end else if (grant_o[REQ_B]) begin
            last_served_d = REQ_B;
        end
    end

    // Reset to B so A wins the very first tie.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            last_served_q <= REQ_B;
        end else begin
            last_served_q <= last_served_d;
        end
    end

    assign last_served_o = last_served_q;

endmodule

// File: rtl/dual_counter_scheduler.sv
// Dual-counter scheduler: shares one dual-nibble counter datapath between requesters A and B.
// Optional macro JOB_COUNT_EN adds the 8-bit jobs_done output counting completed jobs.
module dual_counter_scheduler
    import dual_counter_sched_pkg::*;
#(
    parameter int LEN_W = 4,
    parameter int DP_W  = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [LEN_W-1:0] len_a,
    input  logic [LEN_W-1:0] len_b,
    input  logic             fast_a,
    input  logic             fast_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             busy,
    output logic             done,
    output logic [DP_W-1:0]  result,
    output logic             dp_clear,
    output logic             dp_step_sel,
    input  logic [DP_W-1:0]  dp_value
`ifdef JOB_COUNT_EN
    ,
    output logic [7:0]       jobs_done
`endif
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] run_cnt_q, run_cnt_d;
    logic             mode_q, mode_d;
    logic [DP_W-1:0]  result_q, result_d;
    logic [1:0]       grant;
    logic             last_served;
    logic             owner_req;

    rr_arbiter_2 u_arb (
        .clk           (clk),
        .clear_n       (clear_n),
        .req_i         ({req_b, req_a}),
        .enable_i      (state_q == IDLE),
        .grant_o       (grant),
        .last_served_o (last_served)
    );

    // last_served is updated at grant time, so it also names the current owner.
    assign owner_req = (last_served == REQ_A) ? req_a : req_b;

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        mode_d    = mode_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    run_cnt_d = grant[REQ_B] ? len_b : len_a;
                    mode_d    = grant[REQ_B] ? fast_b : fast_a;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    state_d = IDLE;
                end else if (run_cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    run_cnt_d = run_cnt_q - LEN_W'(1);
                end
            end
            CAPTURE: begin
                if (!owner_req) begin
                    state_d = IDLE;
                end else begin
                    result_d = dp_value;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= IDLE;
            run_cnt_q <= '0;
            mode_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            mode_q    <= mode_d;
            result_q  <= result_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign gnt_a       = busy && (last_served == REQ_A);
    assign gnt_b       = busy && (last_served == REQ_B);
    assign done        = (state_q == DONE);
    assign result      = result_q;
    assign dp_clear    = (state_q != RUN);
    assign dp_step_sel = (state_q == RUN && mode_q) ? STEP_FAST : STEP_SLOW;

`ifdef JOB_COUNT_EN
    logic [7:0] jobs_q;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            jobs_q <= '0;
        end else if (state_q == DONE) begin
            jobs_q <= jobs_q + 8'd1;
        end
    end

    assign jobs_done = jobs_q;
`endif

endmodule

// File: tb/tb_dual_counter_scheduler.sv
// Self-checking bench for dual_counter_scheduler with a behavioural counter datapath
// and an arithmetic reference for the captured result and round-robin order.
module tb_dual_counter_scheduler;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       req_a, req_b;
    logic [3:0] len_a, len_b;
    logic       fast_a, fast_b;
    logic       gnt_a, gnt_b, busy, done;
    logic [7:0] result;
    logic       dp_clear, dp_step_sel;
    logic [7:0] dp_value = 8'h00;
`ifdef JOB_COUNT_EN
    logic [7:0] jobs_done;
`endif

    int checks     = 0;
    int errors     = 0;
    int exp_jobs   = 0;
    bit model_last = 1'b1;

    dual_counter_scheduler #(.LEN_W(4), .DP_W(8)) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .req_a       (req_a),
        .req_b       (req_b),
        .len_a       (len_a),
        .len_b       (len_b),
        .fast_a      (fast_a),
        .fast_b      (fast_b),
        .gnt_a       (gnt_a),
        .gnt_b       (gnt_b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .dp_clear    (dp_clear),
        .dp_step_sel (dp_step_sel),
        .dp_value    (dp_value)
`ifdef JOB_COUNT_EN
        ,
        .jobs_done   (jobs_done)
`endif
    );

    always #5 clk = ~clk;

    // Counter datapath: low nibble +1, high nibble +3 (fast) or +1 when low nibble is 7 (slow).
    always @(posedge clk) begin
        if (dp_clear) begin
            dp_value <= 8'h00;
        end else begin
            dp_value[3:0] <= dp_value[3:0] + 4'd1;
            dp_value[7:4] <= dp_value[7:4] + (dp_step_sel ? {3'b000, dp_value[3:0] == 4'd7} : 4'd3);
        end
    end

    always @(negedge clk) begin
        if (clear_n === 1'b1) begin
            checks++;
            if (gnt_a && gnt_b) begin
                errors++;
                $display("FAIL grant_exclusive: gnt_a=%0b gnt_b=%0b, required not both high", gnt_a, gnt_b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    // len+1 counts from zero: low nibble = n mod 16; high nibble = 3n (fast) or the number of k<n with k mod 16 == 7.
    function automatic logic [7:0] ref_value(input int len, input bit fast);
        int n, lo, hi;
        n  = len + 1;
        lo = n % 16;
        hi = fast ? (3 * n) % 16 : ((n + 8) / 16) % 16;
        return 8'(hi * 16 + lo);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt_a"}, 32'(gnt_a), 32'd0);
        chk({tag, "_gnt_b"}, 32'(gnt_b), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_dp_clear"}, 32'(dp_clear), 32'd1);
        chk({tag, "_step_sel"}, 32'(dp_step_sel), 32'd1);
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        len_a = 4'd0; len_b = 4'd0;
        fast_a = 1'b0; fast_b = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        clear_n    = 1'b1;
        exp_jobs   = 0;
        model_last = 1'b1;
    endtask

    // Called at a negedge with requests already driven; follows one job through to done.
    task automatic wait_job(input bit exp_b, input logic [7:0] exp_res, input int len,
                            input bit fast, input bit drop, input bit scramble, input string tag);
        int cyc, run_cyc, sel_bad;
        bit got_b;
        cyc = 0;
        while (!(gnt_a || gnt_b) && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_grant_seen"}, 32'(gnt_a || gnt_b), 32'd1);
        if (!(gnt_a || gnt_b)) return;
        got_b = gnt_b;
        chk({tag, "_who"}, 32'(got_b), 32'(exp_b));
        if (scramble) begin
            len_a  = 4'($urandom_range(0, 15));
            len_b  = 4'($urandom_range(0, 15));
            fast_a = 1'($urandom_range(0, 1));
            fast_b = 1'($urandom_range(0, 1));
        end
        cyc = 0; run_cyc = 0; sel_bad = 0;
        while (!done && cyc < 40) begin
            if (!dp_clear) begin
                run_cyc++;
                if (dp_step_sel !== !fast) sel_bad++;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(len + 2));
        chk({tag, "_run_cycles"}, 32'(run_cyc), 32'(len + 1));
        chk({tag, "_step_sel_bad"}, 32'(sel_bad), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'(exp_res));
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        if (done) begin
            exp_jobs++;
            model_last = exp_b;
        end
        if (drop) begin
            if (got_b) req_b = 1'b0;
            else       req_a = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        bit         use_b;
        int         len;
        bit         fast;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit   eb;
        int   jobs;
        logic [7:0] saved;

        vecs[0] = '{1'b0, 3,  1'b1, 8'hC4};
        vecs[1] = '{1'b1, 8,  1'b0, 8'h19};
        vecs[2] = '{1'b0, 0,  1'b1, 8'h31};
        vecs[3] = '{1'b1, 15, 1'b1, 8'h00};
        vecs[4] = '{1'b0, 15, 1'b0, 8'h10};
        vecs[5] = '{1'b1, 6,  1'b0, 8'h07};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].use_b) begin
                req_b = 1'b1; len_b = 4'(vecs[i].len); fast_b = vecs[i].fast;
            end else begin
                req_a = 1'b1; len_a = 4'(vecs[i].len); fast_a = vecs[i].fast;
            end
            wait_job(vecs[i].use_b, vecs[i].exp, vecs[i].len, vecs[i].fast, 1'b1, 1'b0,
                     $sformatf("vec%0d", i));
        end
`ifdef JOB_COUNT_EN
        chk("jobs_after_table", 32'(jobs_done), 32'(exp_jobs));
`endif

        // Tie from reset: A first; A keeps requesting, so B must be served next, then A.
        do_reset();
        req_a = 1'b1; req_b = 1'b1;
        len_a = 4'd0; len_b = 4'd0; fast_a = 1'b1; fast_b = 1'b0;
        wait_job(1'b0, 8'h31, 0, 1'b1, 1'b0, 1'b0, "tie_a1");
        wait_job(1'b1, 8'h01, 0, 1'b0, 1'b1, 1'b0, "tie_b");
        wait_job(1'b0, 8'h31, 0, 1'b1, 1'b1, 1'b0, "tie_a2");

        // Abort: B completes, then A (winning the tie) drops in its 2nd RUN cycle.
        req_b = 1'b1; len_b = 4'd8; fast_b = 1'b0;
        wait_job(1'b1, 8'h19, 8, 1'b0, 1'b1, 1'b0, "pre_abort");
        req_a = 1'b1; len_a = 4'd5; fast_a = 1'b1;
        req_b = 1'b1; len_b = 4'd2; fast_b = 1'b1;
        jobs = 0;
        while (!gnt_a && jobs < 10) begin
            @(negedge clk);
            jobs++;
        end
        chk("abort_gnt_a", 32'(gnt_a), 32'd1);
        @(negedge clk);
        req_a = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result_kept", 32'(result), 32'h19);
        model_last = 1'b0;
        @(negedge clk);
        chk("abort_next_gnt_b", 32'(gnt_b), 32'd1);
        wait_job(1'b1, 8'h93, 2, 1'b1, 1'b1, 1'b0, "post_abort");
`ifdef JOB_COUNT_EN
        chk("jobs_after_abort", 32'(jobs_done), 32'(exp_jobs));
`endif

        // Random request patterns; len/fast are rescrambled after each grant.
        for (int s = 0; s < 30; s++) begin
            req_a  = 1'($urandom_range(0, 1));
            req_b  = 1'($urandom_range(0, 1));
            if (!req_a && !req_b) req_a = 1'b1;
            len_a  = 4'($urandom_range(0, 15));
            len_b  = 4'($urandom_range(0, 15));
            fast_a = 1'($urandom_range(0, 1));
            fast_b = 1'($urandom_range(0, 1));
            jobs = 0;
            while ((req_a || req_b) && jobs < 6) begin
                eb = (req_a && req_b) ? (model_last == 1'b0) : req_b;
                if (eb) wait_job(1'b1, ref_value(int'(len_b), fast_b), int'(len_b), fast_b, 1'b1, 1'b1,
                                 $sformatf("rnd%0d_%0d", s, jobs));
                else    wait_job(1'b0, ref_value(int'(len_a), fast_a), int'(len_a), fast_a, 1'b1, 1'b1,
                                 $sformatf("rnd%0d_%0d", s, jobs));
                jobs++;
                if (jobs < 3 && $urandom_range(0, 1) == 1) begin
                    if (eb) req_b = 1'b1;
                    else    req_a = 1'b1;
                end
            end
            req_a = 1'b0; req_b = 1'b0;
            @(negedge clk);
        end
`ifdef JOB_COUNT_EN
        chk("jobs_after_random", 32'(jobs_done & 8'hFF), 32'(exp_jobs & 255));
`endif

        // Asynchronous reset in the middle of RUN.
        req_a = 1'b1; len_a = 4'd5; fast_a = 1'b1;
        jobs = 0;
        while (!gnt_a && jobs < 10) begin
            @(negedge clk);
            jobs++;
        end
        @(negedge clk);
        chk("midrun_gnt_before", 32'(gnt_a), 32'd1);
        saved = result;
        #2 clear_n = 1'b0;
        #1;
        chk("midrun_gnt_a", 32'(gnt_a), 32'd0);
        check_reset_outputs("midrun");
        if (saved == 8'h00) chk("midrun_prior_result_nonzero", 32'(saved), 32'h1);
        req_a = 1'b0;
        @(negedge clk);
        do_reset();
`ifdef JOB_COUNT_EN
        chk("jobs_after_reset", 32'(jobs_done), 32'd0);
`endif
        req_a = 1'b1; req_b = 1'b1;
        len_a = 4'd1; fast_a = 1'b0; len_b = 4'd2; fast_b = 1'b1;
        wait_job(1'b0, 8'h02, 1, 1'b0, 1'b1, 1'b0, "recover_a");
        wait_job(1'b1, 8'h93, 2, 1'b1, 1'b1, 1'b0, "recover_b");
`ifdef JOB_COUNT_EN
        chk("jobs_final", 32'(jobs_done), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_counter_scheduler.md
Name: dual_counter_scheduler

Overview:
- Controller that shares one dual-nibble counter datapath (lower nibble +1/cycle; upper nibble +3/cycle in fast mode, or +1 when the lower nibble equals 7 in slow mode) between two requesters, A and B.
- Two-way round-robin arbitration; runs the datapath for a requested number of cycles, captures its 8-bit value, and returns it with a one-cycle done pulse.
- Sits between the requesters and the counter datapath; it is the only driver of the datapath's clear and step-select inputs.

Parameters:
- LEN_W, 4, width of len_a/len_b; run length = len+1 cycles (1..2^LEN_W).
- DP_W, 8, datapath value width.

Ports:
- clk  in  1  single system clock, rising edge.
- clear_n  in  1  reset, asynchronous, active-low.
- req_a, req_b  in  1 each  request; held high until done or abort.
- len_a, len_b  in  LEN_W each  run length minus one.
- fast_a, fast_b  in  1 each  1 = fast step mode, 0 = slow.
- gnt_a, gnt_b  out  1 each  grant; at most one high.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; result valid in the same cycle.
- result  out  DP_W  captured datapath value; holds until the next capture.
- dp_clear  out  1  datapath synchronous clear, active-high.
- dp_step_sel  out  1  0 = fast step, 1 = slow step (polarity the datapath expects).
- dp_value  in  DP_W  current datapath value.

Behaviour:
- Reset: clock is clk; reset is clear_n, asynchronous, active-low. In reset: state=IDLE, gnt_a=gnt_b=0, busy=0, done=0, result=0, last_served=B (so A wins the first tie), dp_clear=1, dp_step_sel=1.
- Reset mid-operation takes effect immediately with the same values. No done is issued and result is cleared.
- Moore FSM; outputs decoded from registered state. States: IDLE, RUN, CAPTURE, DONE.
- IDLE:
  - dp_clear=1, which holds the datapath at 0.
  - If exactly one req is high, grant it. If both are high, grant the one that is not last_served.
  - On grant: latch that requester's len into run_cnt and its fast into mode_reg; update last_served; go to RUN.
- RUN:
  - dp_clear=0; dp_step_sel=~mode_reg.
  - run_cnt decrements each cycle; at run_cnt==0 go to CAPTURE. RUN therefore lasts exactly len+1 cycles, giving len+1 datapath counts.
- CAPTURE: dp_clear=1; result<=dp_value on the exiting edge; go to DONE.
- DONE: done=1; then go to IDLE.
- Grant and busy: gnt_x is high through RUN, CAPTURE and DONE. busy=1 in every state except IDLE.
- Latency: req seen in IDLE cycle t → RUN in cycles t+1..t+len+1, CAPTURE at t+len+2, DONE at t+len+3, earliest next grant at t+len+4.
- Abort: if the granted req drops in RUN or CAPTURE, go to IDLE on the next edge. No done is issued, result is unchanged, and last_served keeps the aborted requester.
- Changes to len/fast after grant are ignored.
- A non-granted request waits without limit; round-robin bounds the wait to one job.
- Datapath nibble wrap-around is the datapath's concern; result captures the raw value.

Optional Feature:
- Macro JOB_COUNT_EN.
- When defined: adds output jobs_done (8 bits), which increments by 1 (mod 256) on each done pulse. Aborts do not count. It resets to 0 under clear_n.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package dual_counter_sched_pkg: state encoding (IDLE=2'd0, RUN=2'd1, CAPTURE=2'd2, DONE=2'd3), STEP_FAST=1'b0, STEP_SLOW=1'b1, and requester IDs REQ_A/REQ_B.
- Sub-module rr_arbiter_2:
  - Inputs: clk, clear_n, req[1:0], enable (IDLE).
  - Outputs: one-hot grant and the last_served register.
  - The FSM and run counter stay in the top module.

Test Plan:
- Reset mid-RUN with req_a=1, fast_a=1, len_a=5: clear_n low → gnt_a=0, busy=0, dp_clear=1, result=0 asynchronously, before the next clk edge.
- req_a only, fast_a=1, len_a=3 (against a datapath model): 4 RUN cycles, then done with result=8'hC4, and done occurs 6 cycles after grant.
- req_b only, fast_b=0, len_b=8: result=8'h19; dp_step_sel=1 throughout RUN.
- req_a and req_b both high from reset, each with len=0: A granted first, then B; gnt_a and gnt_b are never high together. A then re-requests while B is still high → B served first next time.
- req_a drops in the 2nd RUN cycle: return to IDLE, no done, result unchanged, and B (if requesting) is granted in the following IDLE cycle.
- With JOB_COUNT_EN: 3 completed jobs and 1 abort → jobs_done=3.
